lector_alertas: RTL and testbench

LECTOR_ALERTAS -- requirements
Module: lector_alertas

---
 rtl/lector_alertas.sv | 181 ++++++++++++++++++
 tb/tb_lector_alertas.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lector_alertas.sv
// lector_alertas: reads an active-low 4-line alert register, confirms a stable
// alert pattern over CONFIRM_N samples, raises an alarm until acknowledged and
// then clears the alert register through its output enable.
//   Latency: with CONFIRM_N=3, alarm rises on the 3rd rising edge after the first low sample.
//   Backpressure: none; Q and ack are sampled every cycle, ack only acts in ALARM.
// Ports:
//   clock, reset       : single clock, synchronous active-high reset
//   Q[3:0]             : alert lines (active-low, bit 0 highest priority)
//   ack                : operator acknowledge (level)
//   OE                 : alert register output enable (0 clears the register)
//   alarm, alert_code  : confirmed unacknowledged alert and its line index
//   pending[3:0]       : lines seen low since alarm entry
//   alarm_count[7:0]   : saturating count of alarm entries since reset
module lector_alertas #(
    parameter int CONFIRM_N = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Q,
    input  logic       ack,
    output logic       OE,
    output logic       alarm,
    output logic [1:0] alert_code,
    output logic [3:0] pending,
    output logic [7:0] alarm_count
);

    localparam logic [2:0] CONF = 3'(CONFIRM_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_ALARM,
        S_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        clr_q, clr_d;
    logic        alarm_q, alarm_d;
    logic [1:0]  code_q, code_d;
    logic [3:0]  pending_q, pending_d;
    logic [7:0]  count_q, count_d;

    logic [3:0]  mask;
    logic [2:0]  cnt_inc;
    logic        enter_alarm;
    logic [3:0]  enter_mask;

    // Lines are active-low: a set bit in mask means that line is asserted.
    assign mask    = ~Q;
    assign cnt_inc = {1'b0, cnt_q} + 3'd1;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        clr_d       = clr_q;
        alarm_d     = alarm_q;
        code_d      = code_q;
        pending_d   = pending_q;
        count_d     = count_q;
        enter_alarm = 1'b0;
        enter_mask  = cand_q;

        case (state_q)
            S_IDLE: begin
                if (mask != 4'b0000) begin
                    cand_d = mask;
                    cnt_d  = 2'd1;
                    if (CONF <= 3'd1) begin
                        enter_alarm = 1'b1;
                        enter_mask  = mask;
                    end else begin
                        state_d = S_CONFIRM;
                    end
                end
            end

            S_CONFIRM: begin
                if (mask == 4'b0000) begin
                    // Glitch: drop the candidate silently.
                    state_d = S_IDLE;
                    cand_d  = 4'b0000;
                    cnt_d   = 2'd0;
                end else if (mask == cand_q) begin
                    if (cnt_inc >= CONF) begin
                        enter_alarm = 1'b1;
                        enter_mask  = cand_q;
                    end else begin
                        cnt_d = cnt_inc[1:0];
                    end
                end else begin
                    // Pattern changed: restart confirmation on the new pattern.
                    cand_d = mask;
                    cnt_d  = 2'd1;
                end
            end

            S_ALARM: begin
                // ack wins over any line that is low in the same cycle.
                if (ack) begin
                    state_d   = S_CLEAR;
                    alarm_d   = 1'b0;
                    pending_d = 4'b0000;
                    code_d    = 2'd0;
                    clr_d     = 1'b0;
                    cand_d    = 4'b0000;
                    cnt_d     = 2'd0;
                end else begin
                    pending_d = pending_q | mask;
                end
            end

            S_CLEAR: begin
                // Two cycles with OE low: one to clear the register, one for
                // its output to settle before lines are trusted again.
                if (clr_q) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b0;
                end else begin
                    clr_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_alarm) begin
            state_d   = S_ALARM;
            alarm_d   = 1'b1;
            code_d    = lowest_idx(enter_mask);
            pending_d = enter_mask;
            cnt_d     = 2'd0;
            if (count_q != 8'd255) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cand_q    <= 4'b0000;
            cnt_q     <= 2'd0;
            clr_q     <= 1'b0;
            alarm_q   <= 1'b0;
            code_q    <= 2'd0;
            pending_q <= 4'b0000;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            clr_q     <= clr_d;
            alarm_q   <= alarm_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign OE          = (state_q != S_CLEAR);
    assign alarm       = alarm_q;
    assign alert_code  = code_q;
    assign pending     = pending_q;
    assign alarm_count = count_q;

endmodule

// File: tb/tb_lector_alertas.sv
// tb_lector_alertas: directed scenarios plus randomized traffic for lector_alertas,
// checked every cycle against a streak-based reference model.
// The alert register in front of the DUT is modelled: it loads src each edge
// unless OE is low, in which case it clears to 4'b1111.
module tb_lector_alertas;

    localparam int N = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] q_line = 4'hF;
    logic [3:0] src = 4'hF;
    logic       ack = 1'b0;
    logic       OE;
    logic       alarm;
    logic [1:0] alert_code;
    logic [3:0] pending;
    logic [7:0] alarm_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_alarm;
    int       m_clear_left;
    int       m_streak;
    bit [3:0] m_streak_mask;
    bit [1:0] m_code;
    bit [3:0] m_pending;
    int       m_count;

    lector_alertas #(.CONFIRM_N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .Q           (q_line),
        .ack         (ack),
        .OE          (OE),
        .alarm       (alarm),
        .alert_code  (alert_code),
        .pending     (pending),
        .alarm_count (alarm_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        q_line <= (OE === 1'b0) ? 4'hF : src;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference: an alarm fires once N identical nonzero
    // masks have been seen in a row outside alarm/clear; ack opens a
    // two-cycle clear window during which inputs are ignored.
    task automatic model_step(input logic [3:0] q, input logic a, input logic r);
        bit [3:0] mask;
        mask = ~q;
        if (r) begin
            m_alarm = 0; m_clear_left = 0; m_streak = 0; m_streak_mask = 0;
            m_code = 0; m_pending = 0; m_count = 0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_alarm) begin
            if (a) begin
                m_alarm = 0; m_pending = 0; m_code = 0;
                m_clear_left = 2; m_streak = 0;
            end else begin
                m_pending |= mask;
            end
        end else begin
            if (mask == 0) m_streak = 0;
            else if (m_streak > 0 && mask == m_streak_mask) m_streak++;
            else begin
                m_streak = 1;
                m_streak_mask = mask;
            end
            if (m_streak >= N) begin
                m_alarm = 1;
                m_pending = mask;
                for (int i = 3; i >= 0; i--) if (mask[i]) m_code = 2'(i);
                if (m_count < 255) m_count++;
                m_streak = 0;
            end
        end
    endtask

    // Drive on the falling edge, advance one rising edge, check on the next falling edge.
    task automatic step(input logic [3:0] s, input logic a, input logic r);
        src = s; ack = a; reset = r;
        model_step(q_line, a, r);
        @(posedge clock);
        @(negedge clock);
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("alert_code", 32'(alert_code), 32'(m_code));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("alarm_count", 32'(alarm_count), 32'(m_count));
        chk("OE", 32'(OE), 32'(m_clear_left == 0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_alarm"}, 32'(alarm), 32'd0);
        chk({tag, "_code"}, 32'(alert_code), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_count"}, 32'(alarm_count), 32'd0);
        chk({tag, "_oe"}, 32'(OE), 32'd1);
    endtask

    task automatic ack_and_clear();
        step(4'hF, 1'b1, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
    endtask

    initial begin
        int hold;
        logic [3:0] cur;
        @(negedge clock);

        // Reset state
        step(4'hF, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b1);
        check_reset_vals("rst");
        step(4'hF, 1'b0, 1'b0);
        check_reset_vals("idle");

        // Confirm: line 0 low; Q shows it after the first edge
        step(4'hE, 1'b0, 1'b0);
        step(4'hE, 1'b0, 1'b0);
        step(4'hE, 1'b0, 1'b0);
        chk("lat_alarm_low", 32'(alarm), 32'd0);
        step(4'hE, 1'b0, 1'b0);
        chk("cfm_alarm", 32'(alarm), 32'd1);
        chk("cfm_code", 32'(alert_code), 32'd0);
        chk("cfm_pending", 32'(pending), 32'b0001);
        chk("cfm_count", 32'(alarm_count), 32'd1);

        // Ack with the line still low: ack wins, register is forced clear
        step(4'hE, 1'b1, 1'b0);
        chk("ack_alarm", 32'(alarm), 32'd0);
        chk("ack_oe0", 32'(OE), 32'd0);
        chk("ack_pending", 32'(pending), 32'd0);
        step(4'hF, 1'b0, 1'b0);
        chk("clr_oe1", 32'(OE), 32'd0);
        chk("clr_q", 32'(q_line), 32'hF);
        step(4'hF, 1'b0, 1'b0);
        chk("clr_done_oe", 32'(OE), 32'd1);
        chk("clr_done_alarm", 32'(alarm), 32'd0);

        // Glitch: two low samples then released
        step(4'hB, 1'b0, 1'b0);
        step(4'hB, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        chk("glitch_alarm", 32'(alarm), 32'd0);
        chk("glitch_count", 32'(alarm_count), 32'd1);

        // Priority freeze: code 3 confirmed, then line 0 falls
        for (int i = 0; i < 4; i++) step(4'h7, 1'b0, 1'b0);
        chk("frz_code_a", 32'(alert_code), 32'd3);
        step(4'h6, 1'b0, 1'b0);
        step(4'h6, 1'b0, 1'b0);
        chk("frz_code_b", 32'(alert_code), 32'd3);
        chk("frz_pending", 32'(pending), 32'b1001);
        ack_and_clear();

        // Reset mid-CONFIRM after two low samples
        step(4'hE, 1'b0, 1'b0);
        step(4'hE, 1'b0, 1'b0);
        step(4'hE, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b1);
        check_reset_vals("rst_cfm");
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0);
        chk("rst_cfm_after", 32'(alarm), 32'd0);

        // Saturation: 260 confirm/ack rounds
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 4; i++) step(4'hD, 1'b0, 1'b0);
            ack_and_clear();
        end
        chk("sat_count", 32'(alarm_count), 32'd255);
        for (int i = 0; i < 4; i++) step(4'hD, 1'b0, 1'b0);
        chk("sat_hold", 32'(alarm_count), 32'd255);
        chk("sat_alarm", 32'(alarm), 32'd1);
        ack_and_clear();

        // Randomized traffic: held patterns of random length, sparse ack and reset
        hold = 0;
        cur = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                cur = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 6);
            end
            hold--;
            step(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
